// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: turns debounced hour/minute/fast-set buttons into select levels and set strobes.
// Optional build macro CLOCK_SET_AUTO_ACCEL_EN enables automatic acceleration after ACCEL_STEPS slow steps.
module clock_set_ctrl #(
  parameter int unsigned ACCEL_STEPS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_slow_set_stb,
  input  logic       i_fast_set_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  input  logic       i_fast_set,
  output logic       o_set_hours,
  output logic       o_set_minutes,
  output logic       o_set_stb,
  output logic       o_fast_active,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOURS   = 3'd1,
    MINUTES = 3'd2,
    CLEAR   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  if (ACCEL_STEPS < 1 || ACCEL_STEPS > 255) begin : g_bad_accel_steps
    $error("clock_set_ctrl: ACCEL_STEPS must be in 1..255");
  end

  state_t state;
  state_t next_state;
  logic   fast_q;
  logic   entry_pending;
  logic   set_hours_q;
  logic   set_minutes_q;
  logic   set_stb_q;
  logic   setting;
  logic   next_setting;
  logic   state_hold;
  logic   fast_active;
  logic   repeat_stb;
  logic   stb_next;

  assign setting      = (state == HOURS) || (state == MINUTES) || (state == CLEAR);
  assign next_setting = (next_state == HOURS) || (next_state == MINUTES) || (next_state == CLEAR);
  assign state_hold   = (next_state == state);
  assign repeat_stb   = fast_active ? i_fast_set_stb : i_slow_set_stb;
  // The entry step and a coincident repeat strobe collapse into a single pulse.
  assign stb_next     = setting && state_hold && (entry_pending || repeat_stb);

`ifdef CLOCK_SET_AUTO_ACCEL_EN
  localparam int CW = $clog2(ACCEL_STEPS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACCEL_STEPS);

  logic [CW-1:0] step_cnt;
  logic          auto_fast;

  assign auto_fast   = (step_cnt == CNT_MAX) && ((state == HOURS) || (state == MINUTES));
  assign fast_active = fast_q | auto_fast;

  // Only genuine slow-rate repeats count toward acceleration, not the entry step.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      step_cnt <= '0;
    end else if (!state_hold) begin
      step_cnt <= '0;
    end else if (setting && !entry_pending && !fast_active && i_slow_set_stb &&
                 (step_cnt != CNT_MAX)) begin
      step_cnt <= step_cnt + 1'b1;
    end
  end
`else
  assign fast_active = fast_q;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_set_hours && i_set_minutes) next_state = CLEAR;
        else if (i_set_hours)             next_state = HOURS;
        else if (i_set_minutes)           next_state = MINUTES;
      end
      HOURS: begin
        if (i_set_hours && i_set_minutes) next_state = CLEAR;
        else if (i_set_minutes)           next_state = MINUTES;
        else if (!i_set_hours)            next_state = IDLE;
      end
      MINUTES: begin
        if (i_set_hours && i_set_minutes) next_state = CLEAR;
        else if (i_set_hours)             next_state = HOURS;
        else if (!i_set_minutes)          next_state = IDLE;
      end
      CLEAR: begin
        if (!(i_set_hours && i_set_minutes)) next_state = RELEASE;
      end
      RELEASE: begin
        if (!i_set_hours && !i_set_minutes) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Select levels are registered from next_state so they move on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      fast_q        <= 1'b0;
      entry_pending <= 1'b0;
      set_hours_q   <= 1'b0;
      set_minutes_q <= 1'b0;
      set_stb_q     <= 1'b0;
    end else begin
      state         <= next_state;
      fast_q        <= i_fast_set;
      entry_pending <= next_setting && !state_hold;
      set_hours_q   <= (next_state == HOURS) || (next_state == CLEAR);
      set_minutes_q <= (next_state == MINUTES) || (next_state == CLEAR);
      set_stb_q     <= stb_next;
    end
  end

  assign o_set_hours   = set_hours_q;
  assign o_set_minutes = set_minutes_q;
  assign o_set_stb     = set_stb_q;
  assign o_fast_active = fast_active;
  assign o_state       = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected strobes, a monitor checks each o_set_stb.
module tb_clock_set_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOURS   = 3'd1;
  localparam logic [2:0] S_MINUTES = 3'd2;
  localparam logic [2:0] S_CLEAR   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

`ifdef CLOCK_SET_AUTO_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic        h;
    logic        m;
    logic        f;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       slow_stb;
  logic       fast_stb;
  logic       btn_h;
  logic       btn_m;
  logic       btn_f;
  logic       set_hours;
  logic       set_minutes;
  logic       set_stb;
  logic       fast_active;
  logic [2:0] state;

  int unsigned cyc;
  int          checks;
  int          failures;
  exp_t        exp_q[$];

  clock_set_ctrl #(.ACCEL_STEPS(4)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_slow_set_stb (slow_stb),
    .i_fast_set_stb (fast_stb),
    .i_set_hours    (btn_h),
    .i_set_minutes  (btn_m),
    .i_fast_set     (btn_f),
    .o_set_hours    (set_hours),
    .o_set_minutes  (set_minutes),
    .o_set_stb      (set_stb),
    .o_fast_active  (fast_active),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the head of the expectation queue, cycle included.
  always @(negedge clk) begin
    if (rst_n && set_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_strobe cyc=%0d state=%0d sel=%b%b fast=%b, required no strobe",
                 cyc, state, set_hours, set_minutes, fast_active);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = '{cyc: cyc, st: state, h: set_hours, m: set_minutes, f: fast_active};
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL strobe got cyc=%0d st=%0d h=%b m=%b f=%b, required cyc=%0d st=%0d h=%b m=%b f=%b",
                   a.cyc, a.st, a.h, a.m, a.f, e.cyc, e.st, e.h, e.m, e.f);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int delta, input logic [2:0] st, input logic h, input logic m,
                         input logic f);
    exp_q.push_back('{cyc: cyc + delta, st: st, h: h, m: m, f: f});
  endtask

  task automatic applyStimulus(input logic h, input logic m, input logic f, input logic s,
                               input logic fs);
    btn_h    = h;
    btn_m    = m;
    btn_f    = f;
    slow_stb = s;
    fast_stb = fs;
    tick();
    slow_stb = 1'b0;
    fast_stb = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic h,
                             input logic m, input logic f);
    checks++;
    if ({state, set_hours, set_minutes, fast_active} !== {st, h, m, f}) begin
      failures++;
      $display("[TB] FAIL %s got st=%0d h=%b m=%b f=%b, required st=%0d h=%b m=%b f=%b",
               name, state, set_hours, set_minutes, fast_active, st, h, m, f);
    end
  endtask

  task automatic checkStbLow(input string name);
    checks++;
    if (set_stb !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s got stb=%b, required 0", name, set_stb);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0; btn_h = 0; btn_m = 0; btn_f = 0; slow_stb = 0; fast_stb = 0;
    repeat (3) tick();
    checkOutput("reset_state", S_IDLE, 0, 0, 0);
    checkStbLow("reset_stb");
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] hours press, slow repeat and acceleration");
    pushExp(2, S_HOURS, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hours_select", S_HOURS, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (!ACC || k <= 4) pushExp(1, S_HOURS, 1, 0, ACC && (k >= 4));
      applyStimulus(1, 0, 0, 1, 0);
      repeat (2) applyStimulus(1, 0, 0, 0, 0);
    end
    checkOutput("accel_state", S_HOURS, 1, 0, ACC);
    for (int k = 0; k < 2; k++) begin
      if (ACC) pushExp(1, S_HOURS, 1, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      repeat (2) applyStimulus(1, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hours_to_idle", S_IDLE, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] entry coincident with slow strobe");
    pushExp(2, S_HOURS, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] clear and staggered release");
    pushExp(2, S_HOURS, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    pushExp(2, S_CLEAR, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("clear_select", S_CLEAR, 1, 1, 0);
    repeat (2) applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      pushExp(1, S_CLEAR, 1, 1, 0);
      applyStimulus(1, 1, 0, 1, 0);
      applyStimulus(1, 1, 0, 0, 0);
    end
    checkOutput("clear_no_accel", S_CLEAR, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("release_select", S_RELEASE, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    repeat (2) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("release_hold", S_RELEASE, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("release_to_idle", S_IDLE, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] fast-set button");
    pushExp(2, S_HOURS, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("fast_button", S_HOURS, 1, 0, 1);
    repeat (2) applyStimulus(1, 0, 1, 0, 0);
    pushExp(1, S_HOURS, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fast_drop", S_HOURS, 1, 0, 0);
    pushExp(1, S_HOURS, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] switch hours to minutes after acceleration");
    pushExp(2, S_HOURS, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      pushExp(1, S_HOURS, 1, 0, ACC && (k == 4));
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
    end
    checkOutput("pre_switch", S_HOURS, 1, 0, ACC);
    pushExp(2, S_MINUTES, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("switch_minutes", S_MINUTES, 0, 1, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    pushExp(1, S_MINUTES, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] reset while entry strobe is due");
    applyStimulus(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    btn_h = 1'b0;
    #1;
    checkOutput("reset_mid_hours", S_IDLE, 0, 0, 0);
    checkStbLow("reset_mid_stb");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("after_reset", S_IDLE, 0, 0, 0);

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_strobes got %0d missing, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
